// File: rtl/dmem_if.sv
// Request/response bundle between the memory stage and its data-memory responder.
// The master issues requests; the slave answers with a one-cycle response.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, LATENCY wait states,
// byte-lane stores and a single-cycle registered response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_hold_q, err_hold_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

  logic          enter_c;
  logic          commit_c;
  logic          err_c;
  logic [AW-1:0] idx_c;

  logic [31:0]   mem [DEPTH_WORDS];

  // Next-state, request latch, commit/read decision and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    err_hold_d = err_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY) - CW'(1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Access happens on the edge entering RESP, using the value being latched.
    idx_c    = addr_d[AW+1:2];
    err_c    = (addr_d[1:0] != 2'b00) || (32'(addr_d[31:2]) >= DEPTH_WORDS);
    enter_c  = (state_d == S_RESP) && (state_q != S_RESP);
    commit_c = enter_c && write_d && !err_c;
    if (enter_c) begin
      err_hold_d = err_c;
      rd_d       = (!write_d && !err_c) ? mem[idx_c] : '0;
    end

    // Response is registered, so it appears the cycle after RESP; ready overlaps it.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE) || (state_q == S_RESP);
    rsp_valid_d = (state_q == S_RESP);
    rsp_rdata_d = rsp_valid_d ? rd_q : '0;
    rsp_err_d   = rsp_valid_d ? err_hold_q : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_q        <= '0;
      err_hold_q  <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      err_hold_q  <= err_hold_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem[idx_c][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 0, 5) driven
// from a vector table plus hand-written reset, back-to-back and abort sequences.
module tb_dmem_responder;
  logic clk;
  logic rst;

  logic        rv [3];
  logic        rw [3];
  logic [31:0] ra [3];
  logic [31:0] rwd[3];
  logic [3:0]  rbe[3];
  logic        rdy  [3];
  logic        rsp_v[3];
  logic [31:0] rsp_d[3];
  logic        rsp_e[3];
  logic        bsy  [3];

  int n_chk;
  int n_fail;

  dmem_if bus0();
  dmem_if bus1();
  dmem_if bus2();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(0)) u_l0 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(5)) u_l5 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.req_valid = rv[0];
  assign bus0.req_write = rw[0];
  assign bus0.req_addr  = ra[0];
  assign bus0.req_wdata = rwd[0];
  assign bus0.req_be    = rbe[0];
  assign rdy[0]   = bus0.req_ready;
  assign rsp_v[0] = bus0.rsp_valid;
  assign rsp_d[0] = bus0.rsp_rdata;
  assign rsp_e[0] = bus0.rsp_err;
  assign bsy[0]   = bus0.busy;

  assign bus1.req_valid = rv[1];
  assign bus1.req_write = rw[1];
  assign bus1.req_addr  = ra[1];
  assign bus1.req_wdata = rwd[1];
  assign bus1.req_be    = rbe[1];
  assign rdy[1]   = bus1.req_ready;
  assign rsp_v[1] = bus1.rsp_valid;
  assign rsp_d[1] = bus1.rsp_rdata;
  assign rsp_e[1] = bus1.rsp_err;
  assign bsy[1]   = bus1.busy;

  assign bus2.req_valid = rv[2];
  assign bus2.req_write = rw[2];
  assign bus2.req_addr  = ra[2];
  assign bus2.req_wdata = rwd[2];
  assign bus2.req_be    = rbe[2];
  assign rdy[2]   = bus2.req_ready;
  assign rsp_v[2] = bus2.rsp_valid;
  assign rsp_d[2] = bus2.rsp_rdata;
  assign rsp_e[2] = bus2.rsp_err;
  assign bsy[2]   = bus2.busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int s, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.d = d; v.be = be;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One request: wait for ready, hold valid through the accept edge, then
  // count posedges after the accept edge until rsp_valid is seen.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    rv[s] = 1'b1; rw[s] = w; ra[s] = a; rwd[s] = d; rbe[s] = be;
    n = 0;
    while (rdy[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rv[s] = 1'b0;
    chk("busy_after_accept", 32'(bsy[s]), 32'd1);
    lat = 0;
    while (rsp_v[s] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    rd = rsp_d[s];
    er = rsp_e[s];
    @(negedge clk);
    chk("rsp_pulse_width", 32'(rsp_v[s]), 32'd0);
    chk("rdata_zero_when_idle", rsp_d[s], 32'd0);
    chk("err_zero_when_idle", 32'(rsp_e[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      rv[s] = 1'b0; rw[s] = 1'b0; ra[s] = '0; rwd[s] = '0; rbe[s] = '0;
    end

    // Vector table: s, write, addr, wdata, be, exp_rdata, exp_err, exp_latency (LATENCY+1)
    vt.push_back(mk(0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_0004, 32'h1122_3344, 4'h5, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hA522_A544, 1'b0, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0,         1'b1, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 3));
    vt.push_back(mk(0, 1'b1, 32'h0000_0FFC, 32'h0000_0001, 4'hF, 32'h0,         1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0000_0001, 1'b0, 3));
    vt.push_back(mk(0, 1'b0, 32'h0000_4002, 32'h0,         4'h0, 32'h0,         1'b1, 3));
    vt.push_back(mk(1, 1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF, 32'h0,         1'b0, 1));
    vt.push_back(mk(1, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'hA, 32'h0,         1'b0, 1));
    vt.push_back(mk(1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hAA02_CC04, 1'b0, 1));
    vt.push_back(mk(1, 1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF, 32'h0,         1'b0, 1));
    vt.push_back(mk(2, 1'b1, 32'h0000_0100, 32'h7777_7777, 4'hF, 32'h0,         1'b1, 6));
    vt.push_back(mk(2, 1'b1, 32'h0000_0008, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 6));

    // Reset held for two cycles: everything quiet, ready low.
    repeat (2) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        chk("rst_ready", 32'(rdy[s]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_v[s]), 32'd0);
        chk("rst_rdata", rsp_d[s], 32'd0);
        chk("rst_err", 32'(rsp_e[s]), 32'd0);
        chk("rst_busy", 32'(bsy[s]), 32'd0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("post_rst_ready", 32'(rdy[s]), 32'd1);
      chk("post_rst_busy", 32'(bsy[s]), 32'd0);
    end

    foreach (vt[i]) begin
      txn(vt[i].s, vt[i].w, vt[i].a, vt[i].d, vt[i].be, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
    end

    // Back-to-back loads with LATENCY=0: accept every 2 cycles.
    @(negedge clk);
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h10; rbe[1] = 4'h0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_rsp_valid_k%0d", k), 32'(rsp_v[1]), 32'((k % 2) == 0));
      chk($sformatf("b2b_ready_k%0d", k), 32'(rdy[1]), 32'(((k % 2) == 0) || (k == 7)));
      chk($sformatf("b2b_busy_k%0d", k), 32'(bsy[1]), 32'(k <= 6));
      if (rsp_v[1] === 1'b1) chk($sformatf("b2b_rdata_k%0d", k), rsp_d[1], 32'h0102_0304);
      if (k == 5) rv[1] = 1'b0;
    end

    // Reset two cycles into a LATENCY=5 store: aborted, never committed.
    @(negedge clk);
    rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 32'h8; rwd[2] = 32'h5A5A_5A5A; rbe[2] = 4'hF;
    @(negedge clk);
    rv[2] = 1'b0;
    chk("abort_accepted_busy", 32'(bsy[2]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bsy[2]), 32'd0);
    chk("abort_ready", 32'(rdy[2]), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_v[2]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_v[2] === 1'b1) seen++;
    end
    chk("abort_no_response", 32'(seen), 32'd0);
    txn(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("abort_load_latency", 32'(lat), 32'd6);
    chk("abort_load_rdata", rd, 32'h0000_0000);
    chk("abort_load_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
